// File: rtl/pixel_packer_pkg.sv
// Shared defaults and helpers for the pixel_packer gearbox.
package pixel_packer_pkg;

    localparam int unsigned PP_IN_WIDTH_DEF  = 24;
    localparam int unsigned PP_OUT_WIDTH_DEF = 32;

    function automatic int unsigned pp_clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/packer_out_slot.sv
// Single-entry output register for pixel_packer; holds the word until the FIFO takes it.
module packer_out_slot #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_fifoFull,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_last,
    output logic             o_slotFree,
    output logic [WIDTH-1:0] o_wordData,
    output logic             o_wordValid,
    output logic             o_wordLast
);

    assign o_slotFree = !o_wordValid || !i_fifoFull;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_wordData  <= '0;
            o_wordValid <= 1'b0;
            o_wordLast  <= 1'b0;
        end else if (i_clear) begin
            o_wordValid <= 1'b0;
            o_wordLast  <= 1'b0;
        end else if (i_load) begin
            o_wordData  <= i_data;
            o_wordValid <= 1'b1;
            o_wordLast  <= i_last;
        end else if (o_wordValid && !i_fifoFull) begin
            o_wordValid <= 1'b0;
            o_wordLast  <= 1'b0;
        end
    end

endmodule

// File: rtl/pixel_packer.sv
// IN_WIDTH -> OUT_WIDTH pixel gearbox with backpressure, end-of-frame flush and clear.
// Define PIXEL_PACKER_LSB_FIRST_EN for LSB-first (right-aligned) packing.
module pixel_packer
    import pixel_packer_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = PP_IN_WIDTH_DEF,
    parameter int unsigned OUT_WIDTH = PP_OUT_WIDTH_DEF,
    parameter int unsigned FILL_W    = pp_clog2(IN_WIDTH + OUT_WIDTH + 1)
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_clear,
    input  logic [IN_WIDTH-1:0]  i_pixelData,
    input  logic                 i_pixelValid,
    input  logic                 i_endOfFrame,
    output logic                 o_pixelReady,
    output logic [OUT_WIDTH-1:0] o_wordData,
    output logic                 o_wordValid,
    output logic                 o_wordLast,
    input  logic                 i_fifoFull
);

    localparam int unsigned ACC_W = IN_WIDTH + OUT_WIDTH;
    localparam logic [FILL_W-1:0] OUT_FILL = FILL_W'(OUT_WIDTH);
    localparam logic [FILL_W-1:0] IN_FILL  = FILL_W'(IN_WIDTH);

    logic [ACC_W-1:0]     r_acc;
    logic [FILL_W-1:0]    r_fill;
    logic                 r_flush;

    logic                 w_slotFree;
    logic                 w_emitNow;
    logic                 w_accept;
    logic                 w_lastNow;
    logic [FILL_W-1:0]    w_take;
    logic [FILL_W-1:0]    w_fillAfter;
    logic [FILL_W-1:0]    w_fillNext;
    logic [ACC_W-1:0]     w_accShift;
    logic [ACC_W-1:0]     w_pixelExt;
    logic [ACC_W-1:0]     w_accNext;
    logic [OUT_WIDTH-1:0] w_word;

    always_comb begin
        w_take      = (r_fill >= OUT_FILL) ? OUT_FILL : r_fill;
        w_emitNow   = w_slotFree && ((r_fill >= OUT_FILL) || (r_flush && (r_fill != '0)));
        w_fillAfter = r_fill - (w_emitNow ? w_take : '0);
        w_lastNow   = r_flush && (w_fillAfter == '0);
        o_pixelReady = !i_reset && !i_clear && !r_flush && (w_fillAfter < OUT_FILL);
        w_accept    = i_pixelValid && o_pixelReady;
        w_fillNext  = w_fillAfter + (w_accept ? IN_FILL : '0);
    end

    // The incoming pixel is positioned relative to the post-emit fill, so emit and accept share a cycle.
    always_comb begin
`ifdef PIXEL_PACKER_LSB_FIRST_EN
        w_word     = r_acc[OUT_WIDTH-1:0];
        w_accShift = r_acc >> OUT_WIDTH;
        w_pixelExt = ACC_W'(i_pixelData) << w_fillAfter;
`else
        w_word     = r_acc[ACC_W-1 -: OUT_WIDTH];
        w_accShift = r_acc << OUT_WIDTH;
        w_pixelExt = {i_pixelData, {OUT_WIDTH{1'b0}}} >> w_fillAfter;
`endif
        w_accNext = (w_emitNow ? w_accShift : r_acc) | (w_accept ? w_pixelExt : '0);
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_acc   <= '0;
            r_fill  <= '0;
            r_flush <= 1'b0;
        end else if (i_clear) begin
            r_acc   <= '0;
            r_fill  <= '0;
            r_flush <= 1'b0;
        end else begin
            r_acc  <= w_accNext;
            r_fill <= w_fillNext;
            if (w_emitNow && w_lastNow) begin
                r_flush <= 1'b0;
            end else if (w_accept && i_endOfFrame) begin
                r_flush <= 1'b1;
            end
        end
    end

    packer_out_slot #(
        .WIDTH (OUT_WIDTH)
    ) u_out_slot (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_clear     (i_clear),
        .i_fifoFull  (i_fifoFull),
        .i_load      (w_emitNow),
        .i_data      (w_word),
        .i_last      (w_lastNow),
        .o_slotFree  (w_slotFree),
        .o_wordData  (o_wordData),
        .o_wordValid (o_wordValid),
        .o_wordLast  (o_wordLast)
    );

endmodule

// File: tb/tb_pixel_packer.sv
// Directed self-checking bench for pixel_packer (24 -> 32), both packing orders.
module tb_pixel_packer;

    localparam int unsigned IW = 24;
    localparam int unsigned OW = 32;

`ifdef PIXEL_PACKER_LSB_FIRST_EN
    localparam logic [31:0] S1_W0 = 32'h33AABBCC;
    localparam logic [31:0] S1_W1 = 32'h55661122;
    localparam logic [31:0] S1_W2 = 32'h77889944;
    localparam logic [31:0] S3_W0 = 32'h00AABBCC;
    localparam logic [31:0] S5_W0 = 32'h06010203;
    localparam logic [31:0] S5_W1 = 32'h08090405;
    localparam logic [31:0] S5_W2 = 32'h0A0B0C07;
`else
    localparam logic [31:0] S1_W0 = 32'hAABBCC11;
    localparam logic [31:0] S1_W1 = 32'h22334455;
    localparam logic [31:0] S1_W2 = 32'h66778899;
    localparam logic [31:0] S3_W0 = 32'hAABBCC00;
    localparam logic [31:0] S5_W0 = 32'h01020304;
    localparam logic [31:0] S5_W1 = 32'h05060708;
    localparam logic [31:0] S5_W2 = 32'h090A0B0C;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          clr;
    logic [IW-1:0] pix;
    logic          valid;
    logic          eof;
    logic          ready;
    logic [OW-1:0] wdata;
    logic          wvalid;
    logic          wlast;
    logic          full;

    int n_checks = 0;
    int n_errors = 0;
    int stalls   = 0;
    logic [32:0] words[$];

    pixel_packer #(
        .IN_WIDTH  (IW),
        .OUT_WIDTH (OW)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_clear      (clr),
        .i_pixelData  (pix),
        .i_pixelValid (valid),
        .i_endOfFrame (eof),
        .o_pixelReady (ready),
        .o_wordData   (wdata),
        .o_wordValid  (wvalid),
        .o_wordLast   (wlast),
        .i_fifoFull   (full)
    );

    always #5 clk = ~clk;

    // Record each word that will transfer on the coming rising edge.
    always @(negedge clk) begin
        if (!rst && wvalid && !full) words.push_back({wlast, wdata});
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [IW-1:0] d, input logic last);
        int n;
        n = 0;
        valid = 1'b1;
        pix   = d;
        eof   = last;
        @(negedge clk);
        while (!ready && n < 100) begin
            stalls++;
            n++;
            @(negedge clk);
        end
        if (n >= 100) check_eq("send_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
        valid = 1'b0;
        eof   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_q(input string tag, input int n,
                           input logic [32:0] e0, input logic [32:0] e1, input logic [32:0] e2);
        logic [32:0] e[3];
        logic [32:0] g;
        e[0] = e0;
        e[1] = e1;
        e[2] = e2;
        check_eq({tag, "_count"}, 64'(words.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            g = 'x;
            if (i < words.size()) g = words[i];
            check_eq($sformatf("%s_w%0d", tag, i), 64'(g), 64'(e[i]));
        end
        words.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        clr   = 1'b0;
        pix   = '0;
        valid = 1'b0;
        eof   = 1'b0;
        full  = 1'b0;
        #12;
        check_eq("rst_valid", 64'(wvalid), 64'd0);
        check_eq("rst_data",  64'(wdata),  64'd0);
        check_eq("rst_last",  64'(wlast),  64'd0);
        check_eq("rst_ready", 64'(ready),  64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // Streaming, no backpressure.
        stalls = 0;
        send(24'hAABBCC, 1'b0);
        send(24'h112233, 1'b0);
        send(24'h445566, 1'b0);
        send(24'h778899, 1'b0);
        idle(4);
        check_eq("s1_ready_stalls", 64'(stalls), 64'd0);
        check_q("s1", 3, {1'b0, S1_W0}, {1'b0, S1_W1}, {1'b0, S1_W2});

        // FIFO full for 5 cycles after the first word.
        stalls = 0;
        fork
            begin
                send(24'hAABBCC, 1'b0);
                send(24'h112233, 1'b0);
                send(24'h445566, 1'b0);
                send(24'h778899, 1'b0);
            end
            begin
                int n;
                n = 0;
                while (!wvalid && n < 50) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                full = 1'b1;
                repeat (5) begin
                    @(posedge clk);
                    #1;
                    check_eq("s2_hold", 64'({wvalid, wdata}), 64'({1'b1, S1_W0}));
                end
                full = 1'b0;
            end
        join
        idle(6);
        check_eq("s2_ready_dropped", 64'(stalls > 0), 64'd1);
        check_q("s2", 3, {1'b0, S1_W0}, {1'b0, S1_W1}, {1'b0, S1_W2});

        // Single pixel with end of frame: padded last word.
        send(24'hAABBCC, 1'b1);
        check_eq("s3_ready_flush", 64'(ready),  64'd0);
        check_eq("s3_valid_pre",   64'(wvalid), 64'd0);
        @(posedge clk);
        #1;
        check_eq("s3_word", 64'({wvalid, wlast, wdata}), 64'({1'b1, 1'b1, S3_W0}));
        check_eq("s3_ready_post", 64'(ready), 64'd1);
        idle(3);
        check_q("s3", 1, {1'b1, S3_W0}, 33'd0, 33'd0);

        // End of frame on an exact word boundary: no padding word.
        send(24'hAABBCC, 1'b0);
        send(24'h112233, 1'b0);
        send(24'h445566, 1'b0);
        send(24'h778899, 1'b1);
        idle(4);
        check_q("s4", 3, {1'b0, S1_W0}, {1'b0, S1_W1}, {1'b1, S1_W2});

        // Clear discards partial data.
        send(24'hDEADBE, 1'b0);
        send(24'h123456, 1'b0);
        clr = 1'b1;
        #1;
        check_eq("s5_clr_ready", 64'(ready), 64'd0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        check_eq("s5_clr_valid", 64'(wvalid), 64'd0);
        send(24'h010203, 1'b0);
        send(24'h040506, 1'b0);
        send(24'h070809, 1'b0);
        send(24'h0A0B0C, 1'b0);
        idle(4);
        check_q("s5", 3, {1'b0, S5_W0}, {1'b0, S5_W1}, {1'b0, S5_W2});

        // Asynchronous reset while a word is held.
        full = 1'b1;
        send(24'hAABBCC, 1'b0);
        send(24'h112233, 1'b0);
        @(posedge clk);
        #1;
        check_eq("s6_pre_word", 64'({wvalid, wdata}), 64'({1'b1, S1_W0}));
        #2;
        rst = 1'b1;
        #1;
        check_eq("s6_rst_valid", 64'(wvalid), 64'd0);
        check_eq("s6_rst_data",  64'(wdata),  64'd0);
        check_eq("s6_rst_last",  64'(wlast),  64'd0);
        check_eq("s6_rst_ready", 64'(ready),  64'd0);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        full = 1'b0;
        idle(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
